// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, sizes and helpers for the display scan controller
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 8;
    localparam int SEL_W      = 2;

    // Digit index to one-hot enable
    function automatic logic [NUM_DIGITS-1:0] onehot4(input logic [SEL_W-1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/digit_bank.sv
// rtl/digit_bank.sv - staging and active segment banks with frame-synchronous copy
module digit_bank
    import display_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_addr,
    input  logic [SEG_W-1:0] wr_data,
    input  logic             commit,
    input  logic [SEL_W-1:0] rd_idx,
    output logic [SEG_W-1:0] rd_data
);

    logic [SEG_W-1:0] staging [NUM_DIGITS];
    logic [SEG_W-1:0] active  [NUM_DIGITS];

    // Host writes land in staging only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) staging[i] <= '0;
        end else if (wr_en) begin
            staging[wr_addr] <= wr_data;
        end
    end

    // Commit copies the pre-edge staging contents, so a same-cycle write waits for the next commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) active[i] <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) active[i] <= staging[i];
        end
    end

    assign rd_data = active[rd_idx];

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - four-digit blanked scan FSM with tear-free bank commit
module display_scan_controller
    import display_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 10,
    parameter int CNT_W        = 16
) (
    input  logic                  Up_clk,
    input  logic                  Up_reset,
    input  logic                  Scan_en,
    input  logic                  Wr_en,
    input  logic [SEL_W-1:0]      Wr_addr,
    input  logic [SEG_W-1:0]      Wr_data,
    input  logic                  Commit_req,
    output logic                  Commit_ack,
    input  logic [NUM_DIGITS-1:0] Blank_mask,
    output logic [SEL_W-1:0]      Choose_light,
    output logic [NUM_DIGITS-1:0] Digit_en,
    output logic [SEG_W-1:0]      Digital_light,
    output logic                  Frame_done
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_DIGIT = SEL_W'(NUM_DIGITS - 1);

    scan_state_t      state;
    logic [SEL_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             pending;
    logic             boundary;
    logic             commit_now;
    logic [SEG_W-1:0] active_seg;

    digit_bank u_bank (
        .clk     (Up_clk),
        .rst     (Up_reset),
        .wr_en   (Wr_en),
        .wr_addr (Wr_addr),
        .wr_data (Wr_data),
        .commit  (commit_now),
        .rd_idx  (idx),
        .rd_data (active_seg)
    );

    // Frame boundary is the edge leaving the last digit's SHOW; an idle controller commits at once
    always_comb begin
        boundary   = (state == SHOW) && Scan_en && (idx == LAST_DIGIT) && (cnt == DWELL_LAST);
        commit_now = ((state == IDLE) && pending) || (boundary && (pending || Commit_req));
    end

    // Scan sequencing, commit bookkeeping and registered outputs
    always_ff @(posedge Up_clk or posedge Up_reset) begin
        if (Up_reset) begin
            state         <= IDLE;
            idx           <= '0;
            cnt           <= '0;
            pending       <= 1'b0;
            Commit_ack    <= 1'b0;
            Frame_done    <= 1'b0;
            Choose_light  <= '0;
            Digit_en      <= '0;
            Digital_light <= '0;
        end else begin
            Commit_ack <= commit_now;
            Frame_done <= 1'b0;
            pending    <= commit_now ? 1'b0 : (pending | Commit_req);

            if (state != IDLE && !Scan_en) begin
                state         <= IDLE;
                idx           <= '0;
                cnt           <= '0;
                Choose_light  <= '0;
                Digit_en      <= '0;
                Digital_light <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        Choose_light  <= '0;
                        Digit_en      <= '0;
                        Digital_light <= '0;
                        if (Scan_en) begin
                            state <= BLANK;
                            idx   <= '0;
                            cnt   <= '0;
                        end
                    end
                    BLANK: begin
                        Choose_light <= idx;
                        if (cnt == BLANK_LAST) begin
                            state         <= SHOW;
                            cnt           <= '0;
                            Digit_en      <= Blank_mask[idx] ? '0 : onehot4(idx);
                            Digital_light <= Blank_mask[idx] ? '0 : active_seg;
                        end else begin
                            cnt           <= cnt + 1'b1;
                            Digit_en      <= '0;
                            Digital_light <= '0;
                        end
                    end
                    SHOW: begin
                        if (cnt == DWELL_LAST) begin
                            state         <= BLANK;
                            idx           <= idx + 1'b1;
                            cnt           <= '0;
                            Choose_light  <= idx + 1'b1;
                            Digit_en      <= '0;
                            Digital_light <= '0;
                            Frame_done    <= (idx == LAST_DIGIT);
                        end else begin
                            cnt           <= cnt + 1'b1;
                            Choose_light  <= idx;
                            Digit_en      <= Blank_mask[idx] ? '0 : onehot4(idx);
                            Digital_light <= Blank_mask[idx] ? '0 : active_seg;
                        end
                    end
                    default: begin
                        state         <= IDLE;
                        idx           <= '0;
                        cnt           <= '0;
                        Choose_light  <= '0;
                        Digit_en      <= '0;
                        Digital_light <= '0;
                    end
                endcase
            end
        end
    end

endmodule
